// File: rtl/scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_driver                                                     |
// | Purpose  : Time-multiplexed scan stage for a four-digit seven-segment      |
// |            display. Holds a double-buffered 16-bit value plus per-digit    |
// |            decimal points, steps through the digits at CLK_DIV cycles per  |
// |            digit, and presents the selected nibble to a downstream         |
// |            segment decoder. New data is committed only at frame ends.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk       in   1   system clock, rising edge                            |
// |   rst_n     in   1   asynchronous active-low reset                        |
// |   value     in  16   display value, digit k = value[4k+3:4k]              |
// |   dp_in     in   4   decimal points, active-high, bit k = digit k         |
// |   load      in   1   capture value/dp_in into the pending buffer          |
// |   blank_lz  in   1   leading-zero blanking enable (live level)            |
// |   w,x,y,z   out  1   selected nibble, w = MSB                              |
// |   dp        out  1   decimal point of selected digit, active-low          |
// |   an        out  4   digit anodes, active-low                             |
// |   busy      out  1   pending data waiting for commit                      |
// |   frame     out  1   last cycle of each frame                             |
// +----------------------------------------------------------------------------+
module scan_driver #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy,
  output logic        frame
);

  localparam int                  c_PCNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(CLK_DIV - 1);

  logic [c_PCNT_W-1:0] r_pcnt;
  logic [1:0]          r_sel;
  logic [15:0]         r_pend_val;
  logic [3:0]          r_pend_dp;
  logic                r_busy;
  logic [15:0]         r_disp_val;
  logic [3:0]          r_disp_dp;

  logic       w_tick;
  logic       w_boundary;
  logic [3:0] w_nib;
  logic       w_zero3;
  logic       w_zero2;
  logic       w_zero1;
  logic       w_blank;

  assign w_tick     = (r_pcnt == c_PCNT_LAST);
  assign w_boundary = w_tick && (r_sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt     <= '0;
      r_sel      <= 2'd0;
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_busy     <= 1'b0;
      r_disp_val <= 16'h0000;
      r_disp_dp  <= 4'h0;
    end else begin
      if (w_tick) begin
        r_pcnt <= '0;
        r_sel  <= r_sel + 2'd1;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      // A load always wins over a commit in the same cycle, so a load landing
      // on the boundary keeps busy set and defers the commit a full frame.
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
        r_busy     <= 1'b1;
      end else if (w_boundary && r_busy) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_busy     <= 1'b0;
      end
    end
  end

  // Digit k is a leading zero when nibbles k..3 are all zero.
  assign w_zero3 = (r_disp_val[15:12] == 4'h0);
  assign w_zero2 = w_zero3 && (r_disp_val[11:8] == 4'h0);
  assign w_zero1 = w_zero2 && (r_disp_val[7:4] == 4'h0);

  always_comb begin
    w_nib   = r_disp_val[3:0];
    w_blank = 1'b0;
    an      = 4'b1110;
    case (r_sel)
      2'd0: begin
        w_nib   = r_disp_val[3:0];
        w_blank = 1'b0;
        an      = 4'b1110;
      end
      2'd1: begin
        w_nib   = r_disp_val[7:4];
        w_blank = blank_lz && w_zero1;
        an      = 4'b1101;
      end
      2'd2: begin
        w_nib   = r_disp_val[11:8];
        w_blank = blank_lz && w_zero2;
        an      = 4'b1011;
      end
      default: begin
        w_nib   = r_disp_val[15:12];
        w_blank = blank_lz && w_zero3;
        an      = 4'b0111;
      end
    endcase
    dp = ~r_disp_dp[r_sel];
    if (w_blank) begin
      an = 4'b1111;
      dp = 1'b1;
    end
  end

  assign {w, x, y, z} = w_nib;
  assign busy         = r_busy;
  assign frame        = w_boundary;

endmodule
`default_nettype wire

// File: doc/scan_driver.md
# scan_driver

Time-multiplexing scan stage for the four-digit seven-segment display. It holds a 16-bit display value plus per-digit decimal points and steps through the digits at a programmable refresh rate. Each cycle it presents the selected digit's nibble on `w,x,y,z` for the downstream combinational segment decoder, and drives the active-low digit anodes and the decimal point. New values are double-buffered and committed only at frame boundaries, so a frame never tears.

## Interface
Parameters:
- `CLK_DIV`, default 100000: clock cycles each digit is lit (dwell). Legal range 1 to 2^20.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `value`  in  16  display value; digit k = `value[4k+3:4k]`, digit 0 is rightmost.
- `dp_in`  in  4  decimal point per digit, active-high; bit k = digit k.
- `load`  in  1  single-cycle request to capture `value` and `dp_in`.
- `blank_lz`  in  1  leading-zero blanking enable (level, sampled live).
- `w`, `x`, `y`, `z`  out  1 each  nibble of the selected digit; `w` = MSB, `z` = LSB.
- `dp`  out  1  decimal point for the selected digit, active-low.
- `an`  out  4  digit enables, active-low, one-hot-low or all ones.
- `busy`  out  1  a captured value is waiting for commit.
- `frame`  out  1  high for one cycle in the last cycle of each frame.

## Operation
- Prescaler `pcnt` counts 0 to CLK_DIV-1, then wraps to 0. `tick` = (`pcnt` == CLK_DIV-1).
- Digit select `sel` (2 bits) increments on `tick` and wraps from 3 to 0.
- `boundary` = `tick` && `sel` == 3. The `frame` output equals `boundary`, derived combinationally from registers.
- Pending registers: `load` = 1 captures `value` and `dp_in` into `pend_val` and `pend_dp`, and sets `busy`. A load while `busy` is already set overwrites the pending registers (last load wins).
- Commit: on a `boundary` edge with `busy` set and no `load` in that cycle, copy the pending registers into the display registers `disp_val` and `disp_dp`, and clear `busy`.
- `load` in a `boundary` cycle: the pending registers take the new data and `busy` stays 1. The commit is deferred to the next boundary.
- Leading-zero blanking: digit k (k = 1, 2 or 3) is blanked when `blank_lz` = 1 and `disp_val` nibbles k through 3 are all zero. Digit 0 is never blanked.
- Outputs are combinational from the registered `sel`, `disp_val` and `disp_dp`:
  - `{w,x,y,z}` = `disp_val[4*sel+3 : 4*sel]`.
  - Unblanked digit: `an` = ~(1 << `sel`), `dp` = ~`disp_dp[sel]`.
  - Blanked digit: `an` = 4'b1111, `dp` = 1. `{w,x,y,z}` still carries the nibble (0000).
- Reset asserted, including mid-frame: `pcnt` = 0, `sel` = 0, display and pending registers = 0, `busy` = 0.
  - Outputs during reset: `an` = 4'b1110, `{w,x,y,z}` = 0000, `dp` = 1, `frame` = 0.
  - After release, the scan restarts at digit 0.

## Timing
- Dwell per digit: exactly CLK_DIV cycles. Frame length: 4·CLK_DIV cycles.
- `sel` and `an` change on the edge that ends a `tick` cycle.
- `frame` goes high in the final cycle of the digit-3 slot.
- `busy` rises on the edge that samples `load` (visible the next cycle). It falls on the commit edge.
- Load-to-display latency:
  - At least 1 cycle.
  - At most 4·CLK_DIV + 1 cycles when `load` coincides with a boundary.
  - The new value first appears in the digit-0 slot.
- `blank_lz` takes effect combinationally on the current slot.
- CLK_DIV = 1: `tick` is constantly 1, `sel` advances every cycle, and `frame` pulses every 4th cycle.

## Test plan
- Reset (CLK_DIV = 4), then `rst_n` pulsed low mid-slot at `sel` = 2:
  - `an` = 1110, `wxyz` = 0000, `dp` = 1, `busy` = 0, `frame` = 0 immediately.
  - After release, the scan resumes at digit 0 with a fresh 4-cycle dwell.
- Basic load: `value` = 16'h1234, `dp_in` = 4'b0100, pulse `load` after reset.
  - `busy` = 1 until the first `frame` edge.
  - Next frame: `an` = 1110/1101/1011/0111 for 4 cycles each.
  - `wxyz` = 0100/0011/0010/0001 respectively.
  - `dp` = 0 only during the digit-2 slot.
- Blanking: `blank_lz` = 1.
  - With 16'h0050: digit 3 and digit 2 slots give `an` = 1111, digit 1 shows 0101, digit 0 shows 0000.
  - With 16'h0000: only digit 0 is lit.
  - With `blank_lz` = 0 and 16'h0000: all four digits lit.
- Overwrite: `load` 16'h1111, then `load` 16'h2222 three cycles later, both within one frame. The display never shows 1s; after the next boundary all digits show 0010.
- Load on boundary: assert `load` with 16'hABCD in the `frame` cycle.
  - The following frame still shows the old value.
  - `busy` stays 1.
  - The value 16'hABCD appears after the next `frame` edge.
- CLK_DIV = 1 instance:
  - `an` cycles 1110, 1101, 1011, 0111 on consecutive cycles.
  - `frame` is high every 4th cycle, aligned with `an` = 0111.
